mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 136 +++++++++++++
 tb/tb_mul_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// mul_arbiter: two requesters share one n x n multiplier through a 2-stage
// valid/ready pipeline with round-robin grant.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req_valid[1:0]          per-requester op valid
//   req_ready[1:0]          per-requester accept (at most one bit high)
//   req0_a/b, req1_a/b      operands, n bits each
//   req_signed[1:0]         1 = two's complement multiply for that requester
//   out_valid/out_ready     result handshake
//   out_res[2n-1:0]         product
//   out_id                  requester that issued out_res
module mul_arbiter #(
    parameter int unsigned n = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [n-1:0]      req0_a,
    input  logic [n-1:0]      req0_b,
    input  logic [n-1:0]      req1_a,
    input  logic [n-1:0]      req1_b,
    input  logic [1:0]        req_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*n-1:0]    out_res,
    output logic              out_id
);
    localparam int unsigned RW = 2 * n;

    logic          s1_valid_q, s1_valid_d;
    logic [n-1:0]  s1_a_q, s1_a_d;
    logic [n-1:0]  s1_b_q, s1_b_d;
    logic          s1_signed_q, s1_signed_d;
    logic          s1_id_q, s1_id_d;
    logic          s2_valid_q, s2_valid_d;
    logic [RW-1:0] s2_res_q, s2_res_d;
    logic          s2_id_q, s2_id_d;
    logic          last_q, last_d;

    logic          s2_adv_c;
    logic          s1_accept_c;
    logic          grant_c;
    logic          xfer_c;
    logic [RW-1:0] ext_a_c;
    logic [RW-1:0] ext_b_c;
    logic [RW-1:0] prod_c;

    // Stage advance conditions; S1 acceptance never sees out_ready when S1 is empty.
    assign s2_adv_c    = !s2_valid_q || out_ready;
    assign s1_accept_c = !s1_valid_q || s2_adv_c;

    // Round-robin grant: a lone requester wins, a tie goes to the side not granted last.
    always_comb begin
        grant_c = 1'b0;
        if (req_valid == 2'b11) begin
            grant_c = ~last_q;
        end else if (req_valid[1]) begin
            grant_c = 1'b1;
        end
    end

    // Gated with rst_n so nothing is accepted while reset is held.
    assign req_ready = {grant_c & req_valid[1], ~grant_c & req_valid[0]}
                       & {2{s1_accept_c & rst_n}};
    assign xfer_c    = |(req_valid & req_ready);

    // Operands extended to full result width so a single multiply covers both modes.
    always_comb begin
        ext_a_c = s1_signed_q ? {{n{s1_a_q[n-1]}}, s1_a_q} : {{n{1'b0}}, s1_a_q};
        ext_b_c = s1_signed_q ? {{n{s1_b_q[n-1]}}, s1_b_q} : {{n{1'b0}}, s1_b_q};
        prod_c  = RW'(ext_a_c * ext_b_c);
    end

    // Next-state for both pipeline stages and the round-robin pointer.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_signed_d = s1_signed_q;
        s1_id_d     = s1_id_q;
        s2_valid_d  = s2_valid_q;
        s2_res_d    = s2_res_q;
        s2_id_d     = s2_id_q;
        last_d      = last_q;

        if (s2_adv_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_res_d = prod_c;
                s2_id_d  = s1_id_q;
            end
        end

        if (s1_accept_c) begin
            s1_valid_d = xfer_c;
            if (xfer_c) begin
                s1_a_d      = grant_c ? req1_a : req0_a;
                s1_b_d      = grant_c ? req1_b : req0_b;
                s1_signed_d = req_signed[grant_c];
                s1_id_d     = grant_c;
                last_d      = grant_c;
            end
        end
    end

    // State registers; pointer resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_signed_q <= 1'b0;
            s1_id_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_res_q    <= '0;
            s2_id_q     <= 1'b0;
            last_q      <= 1'b1;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_signed_q <= s1_signed_d;
            s1_id_q     <= s1_id_d;
            s2_valid_q  <= s2_valid_d;
            s2_res_q    <= s2_res_d;
            s2_id_q     <= s2_id_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_id    = s2_id_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter at n=4: directed vector table plus
// hand-written round-robin, backpressure and mid-flight reset sequences.
module tb_mul_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned RW = 2 * N;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [N-1:0]  req0_a, req0_b, req1_a, req1_b;
    logic [1:0]    req_signed;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_res;
    logic          out_id;

    mul_arbiter #(.n(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req_signed (req_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_id     (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          sgn;
        logic          id;
        logic [N-1:0]  a;
        logic [N-1:0]  b;
        logic [RW-1:0] res;
    } vec_t;

    typedef struct packed {
        logic          id;
        logic [RW-1:0] res;
    } exp_t;

    int   checks;
    int   errors;
    int   pops;
    logic mon_en;
    exp_t exp_q[$];
    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic id, input logic sgn, input logic [N-1:0] a, input logic [N-1:0] b);
        req_valid      = id ? 2'b10 : 2'b01;
        req_signed[id] = sgn;
        if (id) begin
            req1_a = a;
            req1_b = b;
        end else begin
            req0_a = a;
            req0_b = b;
        end
    endtask

    // Output scoreboard: a result seen valid+ready at negedge transfers on the next edge.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mon_extra: got id %0d res %0h expected no output", out_id, out_res);
            end else begin
                if (out_id !== exp_q[0].id || out_res !== exp_q[0].res) begin
                    errors++;
                    $display("FAIL mon_out: got id %0d res %0h expected id %0d res %0h",
                             out_id, out_res, exp_q[0].id, exp_q[0].res);
                end
                void'(exp_q.pop_front());
                pops++;
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        pops   = 0;
        mon_en = 1'b0;

        vecs[0] = '{sgn: 1'b0, id: 1'b0, a: 4'hF, b: 4'hF, res: 8'hE1};
        vecs[1] = '{sgn: 1'b1, id: 1'b1, a: 4'h8, b: 4'h8, res: 8'h40};
        vecs[2] = '{sgn: 1'b1, id: 1'b1, a: 4'hF, b: 4'h7, res: 8'hF9};
        vecs[3] = '{sgn: 1'b0, id: 1'b0, a: 4'hC, b: 4'h3, res: 8'h24};
        vecs[4] = '{sgn: 1'b1, id: 1'b0, a: 4'hC, b: 4'h3, res: 8'hF4};
        vecs[5] = '{sgn: 1'b0, id: 1'b1, a: 4'h8, b: 4'h8, res: 8'h40};
        vecs[6] = '{sgn: 1'b1, id: 1'b0, a: 4'h7, b: 4'h7, res: 8'h31};
        vecs[7] = '{sgn: 1'b1, id: 1'b1, a: 4'h8, b: 4'h7, res: 8'hC8};
        vecs[8] = '{sgn: 1'b0, id: 1'b0, a: 4'h0, b: 4'hF, res: 8'h00};

        rst_n      = 1'b0;
        req_valid  = 2'b11;
        req_signed = 2'b00;
        req0_a = 4'h1; req0_b = 4'h1; req1_a = 4'h1; req1_b = 4'h1;
        out_ready  = 1'b1;

        // Reset state
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_res",   32'(out_res),   32'h0);
        chk("rst_id",    32'(out_id),    32'h0);
        tick();
        tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Round-robin with both requesters continuously valid
        for (int i = 0; i < 6; i++) begin
            req_valid = 2'b11;
            req0_a = 4'(i + 1); req0_b = 4'h2;
            req1_a = 4'(i + 1); req1_b = 4'h3;
            #1;
            chk("rr_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            exp_q.push_back('{id: 1'(i % 2), res: 8'((i + 1) * ((i % 2 == 0) ? 2 : 3))});
            tick();
        end
        req_valid = 2'b00;
        repeat (3) tick();
        chk("rr_drained", 32'(exp_q.size()), 32'h0);
        chk("rr_pops",    32'(pops),         32'd6);
        mon_en = 1'b0;

        // Vector table: single ops, latency, operand sampling at the transfer edge
        for (int v = 0; v < 9; v++) begin
            issue(vecs[v].id, vecs[v].sgn, vecs[v].a, vecs[v].b);
            #1;
            chk("tbl_ready", 32'(req_ready), vecs[v].id ? 32'h2 : 32'h1);
            tick();
            req_valid  = 2'b00;
            req0_a     = ~req0_a; req0_b = ~req0_b;
            req1_a     = ~req1_a; req1_b = ~req1_b;
            req_signed = ~req_signed;
            #1;
            chk("tbl_lat1", 32'(out_valid), 32'h0);
            tick();
            chk("tbl_valid", 32'(out_valid), 32'h1);
            chk("tbl_res",   32'(out_res),   32'(vecs[v].res));
            chk("tbl_id",    32'(out_id),    32'(vecs[v].id));
        end
        tick();
        chk("tbl_idle", 32'(out_valid), 32'h0);

        // Backpressure: fill both stages, stall five cycles, then drain in order
        pops      = 0;
        mon_en    = 1'b1;
        out_ready = 1'b0;
        issue(1'b0, 1'b0, 4'h5, 4'h3);
        exp_q.push_back('{id: 1'b0, res: 8'h0F});
        tick();
        issue(1'b1, 1'b1, 4'hE, 4'h3);
        exp_q.push_back('{id: 1'b1, res: 8'hFA});
        #1;
        chk("bp_ready_s1", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_ready", 32'(req_ready), 32'h0);
            chk("bp_valid", 32'(out_valid), 32'h1);
            chk("bp_res",   32'(out_res),   32'h0F);
            chk("bp_id",    32'(out_id),    32'h0);
            tick();
        end
        req_valid = 2'b00;
        out_ready = 1'b1;
        repeat (3) tick();
        chk("bp_drained", 32'(exp_q.size()), 32'h0);
        chk("bp_pops",    32'(pops),         32'd2);
        chk("bp_idle",    32'(out_valid),    32'h0);

        // Reset with both stages full discards in-flight ops
        out_ready = 1'b0;
        issue(1'b0, 1'b0, 4'h9, 4'h9);
        tick();
        issue(1'b1, 1'b0, 4'h2, 4'h2);
        tick();
        req_valid = 2'b00;
        chk("mr_full", 32'(out_valid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(out_valid), 32'h0);
        chk("mr_res",   32'(out_res),   32'h0);
        req_valid = 2'b11;
        #1;
        chk("mr_ready", 32'(req_ready), 32'h0);
        req_valid = 2'b00;
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        pops      = 0;
        repeat (2) tick();
        chk("mr_quiet", 32'(out_valid), 32'h0);
        issue(1'b1, 1'b0, 4'h6, 4'h7);
        exp_q.push_back('{id: 1'b1, res: 8'h2A});
        #1;
        chk("mr_ready2", 32'(req_ready), 32'h2);
        tick();
        req_valid = 2'b00;
        repeat (3) tick();
        chk("mr_drained", 32'(exp_q.size()), 32'h0);
        chk("mr_pops",    32'(pops),         32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
